// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU word layout, status codes and converter states
package fpu_pkg;

  localparam int EXP_W = 6;
  localparam int MAN_W = 25;
  localparam int BIAS  = 31;
  localparam int FP_W  = 1 + EXP_W + MAN_W;

  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0010;
  localparam logic [3:0] ST_UNDERFLOW = 4'b0100;
  localparam logic [3:0] ST_INEXACT   = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic fp_sign(input logic [FP_W-1:0] w);
    return w[FP_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] w);
    return w[FP_W-2 -: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] fp_man(input logic [FP_W-1:0] w);
    return w[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/fpu_to_int.sv
// rtl/fpu_to_int.sv - FPU word to signed integer, serial right shift with round-half-even
module fpu_to_int
  import fpu_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clock100KHz,
  input  logic             reset,
  input  logic [FP_W-1:0]  fp_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] int_out,
  output logic [3:0]       status_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SIG_W   = MAN_W + 1;
  // Exponent at which the significand already is the integer value.
  localparam int EXP_INT = BIAS + MAN_W;
  // Exponent whose magnitude reaches 2^(OUT_W-1): only -2^(OUT_W-1) fits.
  localparam int EXP_SAT = BIAS + OUT_W - 1;
  // Beyond SIG_W+1 shifts every further bit shifted out is zero.
  localparam int MAX_N   = SIG_W + 1;
  localparam int CNT_W   = $clog2(MAX_N + 1);

  localparam logic [EXP_W-1:0] EXP_INT_E = EXP_W'(EXP_INT);
  localparam logic [EXP_W-1:0] EXP_SAT_E = EXP_W'(EXP_SAT);
  localparam logic [EXP_W:0]   MAX_N_R   = (EXP_W + 1)'(MAX_N);
  localparam logic [OUT_W-1:0] INT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] INT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};

  state_t r_state;
  state_t w_state_n;

  logic [SIG_W-1:0] r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic             r_guard;
  logic             r_sticky;
  logic             r_sign;
  logic [OUT_W-1:0] r_int;
  logic [3:0]       r_status;

  logic             w_sign;
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic [SIG_W-1:0] w_sig;
  logic             w_direct;
  logic [OUT_W-1:0] w_load_int;
  logic [3:0]       w_load_status;
  logic [CNT_W-1:0] w_load_cnt;
  logic [EXP_W:0]   w_rshift;
  logic [OUT_W-1:0] w_lshifted;

  logic             w_guard_n;
  logic             w_sticky_n;
  logic [SIG_W-1:0] w_sig_n;
  logic             w_inc;
  logic [SIG_W-1:0] w_mag;
  logic [OUT_W-1:0] w_round_int;
  logic [3:0]       w_round_status;
  logic             w_last;

  assign w_sign = fp_sign(fp_in);
  assign w_exp  = fp_exp(fp_in);
  assign w_man  = fp_man(fp_in);
  assign w_sig  = {1'b1, w_man};

  // Decode the input at load: results needing no right shift are produced here.
  always_comb begin
    w_direct      = 1'b1;
    w_load_int    = '0;
    w_load_status = ST_EXACT;
    w_load_cnt    = '0;
    w_rshift      = (EXP_W + 1)'(EXP_INT) - {1'b0, w_exp};
    w_lshifted    = OUT_W'(w_sig) << (w_exp - EXP_INT_E);
    if (w_exp == '0) begin
      w_load_int = '0;
    end else if (w_exp > EXP_SAT_E || (w_exp == EXP_SAT_E && !(w_sign && w_man == '0))) begin
      w_load_status = ST_OVERFLOW;
      w_load_int    = w_sign ? INT_MIN : INT_MAX;
    end else if (w_exp == EXP_SAT_E) begin
      w_load_int = INT_MIN;
    end else if (w_exp >= EXP_INT_E) begin
      w_load_int = w_sign ? -w_lshifted : w_lshifted;
    end else begin
      w_direct   = 1'b0;
      w_load_cnt = (w_rshift > MAX_N_R) ? CNT_W'(MAX_N) : w_rshift[CNT_W-1:0];
    end
  end

  // One shift step; on the final step the post-shift bits feed the rounder directly.
  always_comb begin
    w_guard_n   = r_sig[0];
    w_sticky_n  = r_sticky | r_guard;
    w_sig_n     = r_sig >> 1;
    w_inc       = w_guard_n & (w_sticky_n | w_sig_n[0]);
    w_mag       = w_sig_n + SIG_W'(w_inc);
    w_round_int = r_sign ? -OUT_W'(w_mag) : OUT_W'(w_mag);
    w_last      = (r_cnt == CNT_W'(1));
    if (w_mag == '0) begin
      w_round_status = ST_UNDERFLOW;
    end else if (w_guard_n | w_sticky_n) begin
      w_round_status = ST_INEXACT;
    end else begin
      w_round_status = ST_EXACT;
    end
  end

  // State register.
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_n = w_direct ? DONE : ALIGN;
      ALIGN:   if (w_last) w_state_n = DONE;
      DONE:    if (out_ready) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Handshake outputs follow the state.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Datapath: load, shift, round; result registers hold through DONE.
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      r_sig    <= '0;
      r_cnt    <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_sign   <= 1'b0;
      r_int    <= '0;
      r_status <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sig    <= w_sig;
            r_sign   <= w_sign;
            r_cnt    <= w_load_cnt;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            if (w_direct) begin
              r_int    <= w_load_int;
              r_status <= w_load_status;
            end
          end
        end
        ALIGN: begin
          r_sig    <= w_sig_n;
          r_guard  <= w_guard_n;
          r_sticky <= w_sticky_n;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_int    <= w_round_int;
            r_status <= w_round_status;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign int_out    = r_int;
  assign status_out = r_status;

endmodule

// File: tb/tb_fpu_to_int.sv
// tb/tb_fpu_to_int.sv - scoreboard bench for fpu_to_int
module tb_fpu_to_int;

  localparam logic [3:0] EX = 4'b0001;
  localparam logic [3:0] OV = 4'b0010;
  localparam logic [3:0] UN = 4'b0100;
  localparam logic [3:0] IN = 4'b1000;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  st;
    int          lat;
    int          acc;
    int          idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fp_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] int_out;
  logic [3:0]  status_out;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   vec_idx = 0;
  exp_t sb[$];

  fpu_to_int dut (
    .clock100KHz(clk),
    .reset(reset),
    .fp_in(fp_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .int_out(int_out),
    .status_out(status_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mkfp(input logic s, input int e, input int m);
    return {s, 6'(e), 25'(m)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [31:0] fp, input logic [31:0] d, input logic [3:0] s, input int lat);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout: vector %0d never accepted", vec_idx);
    end else begin
      fp_in    = fp;
      in_valid = 1'b1;
      e.data = d;
      e.st   = s;
      e.lat  = lat;
      e.acc  = cyc + 1;
      e.idx  = vec_idx;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    vec_idx++;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || out_valid) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d required=0", sb.size());
    end
  endtask

  // Monitor: on each new result, pop the scoreboard and compare.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: actual=%h required=none", int_out);
          end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_data", e.idx), int_out, e.data);
            chk($sformatf("v%0d_status", e.idx), 32'(status_out), 32'(e.st));
            chk($sformatf("v%0d_latency", e.idx), 32'(cyc - e.acc + 1), 32'(e.lat));
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_int_out", int_out, 32'd0);
    chk("reset_status", 32'(status_out), 32'd0);
    out_ready = 1'b1;

    send(mkfp(0, 31, 0),            32'd1,          EX, 26);
    send(mkfp(1, 32, 0),            32'hFFFFFFFE,   EX, 25);
    send(mkfp(0, 33, 0),            32'd4,          EX, 24);
    send(mkfp(0, 32, 1 << 23),      32'd2,          IN, 25);
    send(mkfp(0, 32, 3 << 23),      32'd4,          IN, 25);
    send(mkfp(0, 63, 33554431),     32'h7FFFFFFF,   OV, 1);
    send(mkfp(1, 62, 0),            32'h80000000,   EX, 1);
    send(mkfp(0, 62, 1),            32'h7FFFFFFF,   OV, 1);
    send(mkfp(0, 1, 1),             32'd0,          UN, 28);
    send(mkfp(0, 0, 5),             32'd0,          EX, 1);
    send(mkfp(1, 0, 0),             32'd0,          EX, 1);
    send(mkfp(1, 61, 0),            32'hC0000000,   EX, 1);
    send(mkfp(0, 56, 5),            32'h02000005,   EX, 1);
    send(mkfp(0, 30, 0),            32'd0,          UN, 27);
    send(mkfp(0, 30, 1 << 24),      32'd1,          IN, 27);
    send(mkfp(1, 31, 1 << 24),      32'hFFFFFFFE,   IN, 26);
    send(mkfp(1, 63, 0),            32'h80000000,   OV, 1);
    drain();

    // Back-pressure: result held, busy pulses ignored.
    out_ready = 1'b0;
    send(mkfp(0, 33, 1 << 24), 32'd6, EX, 24);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("hold_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 3 || i == 4);
      fp_in    = mkfp(0, 40, 7);
      chk($sformatf("hold%0d_data", i), int_out, 32'd6);
      chk($sformatf("hold%0d_status", i), 32'(status_out), 32'(EX));
      chk($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("handshake_in_ready_same_cycle", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("handshake_in_ready_next", 32'(in_ready), 32'd1);
    chk("handshake_out_valid_next", 32'(out_valid), 32'd0);
    drain();

    // Reset during ALIGN aborts the conversion.
    send(mkfp(0, 31, 0), 32'd1, EX, 26);
    repeat (5) @(negedge clk);
    chk("abort_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    sb.delete();
    send(mkfp(0, 33, 1 << 24), 32'd6, EX, 24);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_to_int.md
Name: fpu_to_int

Overview:
Decoder at the output side of the FPU. It accepts one 32-bit FPU-format word (1 sign bit, 6-bit exponent with bias 31, 25-bit fraction, implicit leading 1) and converts it to a signed 32-bit two's-complement integer. The converter is an iterative one-bit-per-cycle right shifter with round-to-nearest-even. Status is reported in the same 4-bit one-hot encoding the FPU uses, and both sides use valid/ready handshakes.

Parameters:
EXP_W, 6, exponent field width
MAN_W, 25, fraction field width
BIAS, 31, exponent bias
OUT_W, 32, integer result width (only defaults are verified)

Ports:
clock100KHz  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
fp_in  in  32  {sign, exp[5:0], man[24:0]}
in_valid  in  1  fp_in is valid
in_ready  out  1  block can accept; high only in IDLE
int_out  out  32  signed result, held while out_valid is high
status_out  out  4  one-hot status, held with int_out
out_valid  out  1  result available
out_ready  in  1  consumer takes result

Behaviour:
- Reset (synchronous, active high): state=IDLE, out_valid=0, int_out=0, status_out=0, in_ready=1. Reset mid-conversion aborts the conversion; any pending result is discarded.
- States: IDLE -> ALIGN -> DONE, or IDLE -> DONE directly when shift count N=0.
- Accept occurs on the edge where in_valid&&in_ready. At that edge, load sig={1,man} (26 bits), sign, and the shift count N. in_valid is ignored outside IDLE.
- Zero: exp==0 gives result 0 with EXACT, regardless of man and sign (denormals flushed, -0 -> 0). N=0.
- Overflow: exp==63 gives OVERFLOW. exp==62 also gives OVERFLOW unless sign=1 and man==0, which yields 0x80000000 with EXACT. On OVERFLOW, saturate to 0x7FFFFFFF (sign 0) or 0x80000000 (sign 1). N=0.
- 57<=exp<=61: left shift by exp-56 (at most 5), done combinationally at load. Result is exact. N=0.
- exp<=56: right shift by R=56-exp, with N=min(R,27).
- ALIGN: one bit per cycle. guard<=sig[0], sticky<=sticky|guard, sig>>=1, N decrements. Leave ALIGN when N reaches 0.
- Round on the edge that enters DONE, using round-to-nearest-even: increment if guard&&(sticky||sig[0]).
  - Increment cannot overflow OUT_W.
  - Negate if sign=1.
- Status priority: OVERFLOW > UNDERFLOW > INEXACT > EXACT.
  - UNDERFLOW: nonzero input that rounds to 0.
  - INEXACT: guard|sticky set with a nonzero result.
  - EXACT: otherwise.
- Latency: out_valid rises N+1 cycles after the accept edge, with N in 0..27.
- DONE: out_valid=1, int_out and status_out stable. When out_valid&&out_ready, go to IDLE. in_ready rises the next cycle, not in the same cycle.
- out_ready is ignored while out_valid=0. in_ready=0 in ALIGN and DONE.

Decomposition:
- Shared package fpu_pkg holds:
  - EXP_W, MAN_W, BIAS.
  - Field slice helpers for sign/exp/man.
  - Status constants, identical to the FPU's: ST_EXACT=4'b0001, ST_OVERFLOW=4'b0010, ST_UNDERFLOW=4'b0100, ST_INEXACT=4'b1000.
  - State enum {IDLE, ALIGN, DONE}.
- No sub-module; a single module of about 150-250 lines.

Test Plan:
- fp_in={0,31,0} (+1.0), out_ready=1 -> int_out=32'd1, status=0001, out_valid exactly 26 cycles after accept.
- {1,32,0} (-2.0) -> int_out=32'hFFFFFFFE, status=0001. Then {0,33,0} -> 32'd4, 0001.
- Ties to even: {0,32,2^23} (2.5) -> 32'd2, status 1000. {0,32,3*2^23} (3.5) -> 32'd4, status 1000.
- Saturation: {0,63,all ones} -> 32'h7FFFFFFF, 0010. {1,62,0} -> 32'h80000000, 0001. {0,62,1} -> 32'h7FFFFFFF, 0010. Each has latency 1.
- Small and zero inputs: {0,1,1} -> 0, 0100, N=27. {0,0,5} and {1,0,0} -> 0, 0001, latency 1.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles: int_out/status stay stable and in_ready stays 0.
  - in_valid pulses while busy are ignored.
  - Assert reset during ALIGN -> next cycle out_valid=0, in_ready=1, and a new input converts correctly.
